// File: rtl/user_move_ctrl.sv
// user_move_ctrl
//   Player-input controller for the board game. Turns five debounced button
//   levels into cursor motion and piece select/commit. Each candidate move is
//   sent to an external legality checker over a req/ack handshake. An accepted
//   move is committed to board storage as two valid/ready writes: the
//   destination square first, then clearing of the source square.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   board_flat        square k at [k*PIECE_W +: PIECE_W], k = row*COLS + col
//   btn_c/u/d/l/r     debounced synchronous button levels
//   chk_req           legality request, held until chk_ack
//   chk_ack, chk_ok   checker response strobe and verdict
//   wr_en/addr/data   board write, held until wr_ready
//   wr_ready          board accepts the write when wr_en & wr_ready
//   cursor            cursor square index
//   selection         selected square index, sel_valid while held
//   player_turn       0 white, 1 black
//   state             FSM state (IDLE..CLEAR)
//   move_count        committed moves, wraps at 0xFFFF
//   err_timeout       one-cycle pulse on checker timeout
module user_move_ctrl #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int PIECE_W     = 4,
  parameter int WRAP        = 0,
  parameter int REPEAT_CYC  = 0,
  parameter int CHK_TIMEOUT = 255,
  localparam int N          = ROWS * COLS,
  localparam int AW         = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*PIECE_W-1:0] board_flat,
  input  logic                 btn_c,
  input  logic                 btn_u,
  input  logic                 btn_d,
  input  logic                 btn_l,
  input  logic                 btn_r,
  output logic                 chk_req,
  input  logic                 chk_ack,
  input  logic                 chk_ok,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [PIECE_W-1:0]   wr_data,
  input  logic                 wr_ready,
  output logic [AW-1:0]        cursor,
  output logic [AW-1:0]        selection,
  output logic                 sel_valid,
  output logic                 player_turn,
  output logic [2:0]           state,
  output logic [15:0]          move_count,
  output logic                 err_timeout
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = $clog2(CHK_TIMEOUT + 1);
  localparam int PW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CHK_TIMEOUT - 1);
  localparam logic [PW-1:0] REP_LAST = PW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    ARMED  = 3'd2,
    CHECK  = 3'd3,
    PLACE  = 3'd4,
    CLEAR  = 3'd5
  } state_t;

  state_t               state_q;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [PW-1:0]        rep_cnt_q, rep_cnt_d;
  logic [TW-1:0]        tmo_cnt_q;
  logic [4:0]           btn_q;
  logic [AW-1:0]        sel_q, dst_q, wr_addr_q;
  logic [PIECE_W-1:0]   piece_q, wr_data_q;
  logic                 sel_valid_q, turn_q, chk_req_q, wr_en_q, err_q;
  logic [15:0]          move_cnt_q;

  // Button vector order: {c, u, d, r, l}; low four bits are directions in priority order.
  logic [4:0]           btn_lvl, btn_rise;
  logic [3:0]           want;
  logic                 dir_held, dir_rise, rep_fire, can_move, c_rise, own_cur;
  logic [AW-1:0]        cursor_w;
  logic [PIECE_W-1:0]   sq [N];
  logic [PIECE_W-1:0]   cur_sq, sel_sq;

  for (genvar k = 0; k < N; k++) begin : g_sq
    assign sq[k] = board_flat[k*PIECE_W +: PIECE_W];
  end

  assign btn_lvl  = {btn_c, btn_u, btn_d, btn_r, btn_l};
  assign btn_rise = btn_lvl & ~btn_q;
  assign c_rise   = btn_rise[4];
  assign dir_held = |btn_lvl[3:0];
  assign dir_rise = |btn_rise[3:0];
  // A fresh press restarts the repeat interval, so a repeat never lands right after an edge step.
  assign rep_fire = (REPEAT_CYC > 0) && dir_held && !dir_rise && (rep_cnt_q == REP_LAST);
  assign want     = btn_rise[3:0] | ({4{rep_fire}} & btn_lvl[3:0]);
  assign can_move = (state_q == SELECT) || (state_q == ARMED);

  assign cursor_w = AW'(int'(row_q) * COLS + int'(col_q));
  assign cur_sq   = sq[cursor_w];
  assign sel_sq   = sq[sel_q];
  assign own_cur  = (cur_sq != '0) && (cur_sq[PIECE_W-1] == turn_q);

  // NOTE: every signal written in always_comb takes a default first so no path leaves it unassigned (no latch).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (can_move) begin
      if (want[3])
        row_d = (row_q == '0) ? ((WRAP != 0) ? ROW_MAX : row_q) : row_q - 1'b1;
      else if (want[2])
        row_d = (row_q == ROW_MAX) ? ((WRAP != 0) ? {RW{1'b0}} : row_q) : row_q + 1'b1;
      else if (want[1])
        col_d = (col_q == COL_MAX) ? ((WRAP != 0) ? {CW{1'b0}} : col_q) : col_q + 1'b1;
      else if (want[0])
        col_d = (col_q == '0) ? ((WRAP != 0) ? COL_MAX : col_q) : col_q - 1'b1;
    end
  end

  always_comb begin
    rep_cnt_d = rep_cnt_q + 1'b1;
    if (!dir_held || dir_rise || (rep_cnt_q == REP_LAST))
      rep_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      rep_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      btn_q       <= '0;
      sel_q       <= '0;
      dst_q       <= '0;
      piece_q     <= '0;
      sel_valid_q <= 1'b0;
      turn_q      <= 1'b0;
      chk_req_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      move_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      btn_q     <= btn_lvl;
      row_q     <= row_d;
      col_q     <= col_d;
      rep_cnt_q <= rep_cnt_d;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: state_q <= SELECT;
        SELECT: begin
          if (c_rise && own_cur) begin
            state_q     <= ARMED;
            sel_q       <= cursor_w;
            sel_valid_q <= 1'b1;
          end
        end
        ARMED: begin
          if (c_rise) begin
            if (cursor_w == sel_q) begin
              state_q     <= SELECT;
              sel_valid_q <= 1'b0;
            end else if (own_cur) begin
              sel_q <= cursor_w;
            end else begin
              state_q   <= CHECK;
              dst_q     <= cursor_w;
              piece_q   <= sel_sq;
              chk_req_q <= 1'b1;
              tmo_cnt_q <= '0;
            end
          end
        end
        CHECK: begin
          if (chk_ack) begin
            chk_req_q <= 1'b0;
            tmo_cnt_q <= '0;
            if (chk_ok) begin
              state_q   <= PLACE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= dst_q;
              wr_data_q <= piece_q;
            end else begin
              state_q     <= SELECT;
              sel_valid_q <= 1'b0;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            chk_req_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            state_q     <= SELECT;
            sel_valid_q <= 1'b0;
            err_q       <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        PLACE: begin
          if (wr_ready) begin
            state_q   <= CLEAR;
            wr_addr_q <= sel_q;
            wr_data_q <= '0;
          end
        end
        CLEAR: begin
          if (wr_ready) begin
            state_q     <= SELECT;
            wr_en_q     <= 1'b0;
            sel_valid_q <= 1'b0;
            turn_q      <= ~turn_q;
            move_cnt_q  <= move_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chk_req     = chk_req_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cursor      = cursor_w;
  assign selection   = sel_q;
  assign sel_valid   = sel_valid_q;
  assign player_turn = turn_q;
  assign state       = state_q;
  assign move_count  = move_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_user_move_ctrl.sv
// Bench for user_move_ctrl. Three instances share the stimulus:
//   u_a: 8x8, clamp, no repeat, CHK_TIMEOUT=10
//   u_b: 8x8, wrap, REPEAT_CYC=4
//   u_c: 6x10, clamp, no repeat, CHK_TIMEOUT=10
// Each sequence resets all three and checks only the instance it targets.
module tb_user_move_ctrl;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_L = 5'b00001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_c = 0, btn_u = 0, btn_d = 0, btn_l = 0, btn_r = 0;
  logic chk_ack = 0, chk_ok = 0, wr_ready = 0;
  logic [255:0] board8;
  logic [239:0] board6;

  logic       a_req, a_wen, a_sv, a_turn, a_err;
  logic [5:0] a_waddr, a_cur, a_sel;
  logic [3:0] a_wdata;
  logic [2:0] a_state;
  logic [15:0] a_cnt;

  logic       b_req, b_wen, b_sv, b_turn, b_err;
  logic [5:0] b_waddr, b_cur, b_sel;
  logic [3:0] b_wdata;
  logic [2:0] b_state;
  logic [15:0] b_cnt;

  logic       c_req, c_wen, c_sv, c_turn, c_err;
  logic [5:0] c_waddr, c_cur, c_sel;
  logic [3:0] c_wdata;
  logic [2:0] c_state;
  logic [15:0] c_cnt;

  always #5 clk = ~clk;

  user_move_ctrl #(.ROWS(8), .COLS(8), .WRAP(0), .REPEAT_CYC(0), .CHK_TIMEOUT(10)) u_a (
    .clk(clk), .reset(reset), .board_flat(board8),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .chk_req(a_req), .chk_ack(chk_ack), .chk_ok(chk_ok),
    .wr_en(a_wen), .wr_addr(a_waddr), .wr_data(a_wdata), .wr_ready(wr_ready),
    .cursor(a_cur), .selection(a_sel), .sel_valid(a_sv), .player_turn(a_turn),
    .state(a_state), .move_count(a_cnt), .err_timeout(a_err));

  user_move_ctrl #(.ROWS(8), .COLS(8), .WRAP(1), .REPEAT_CYC(4), .CHK_TIMEOUT(255)) u_b (
    .clk(clk), .reset(reset), .board_flat(board8),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .chk_req(b_req), .chk_ack(chk_ack), .chk_ok(chk_ok),
    .wr_en(b_wen), .wr_addr(b_waddr), .wr_data(b_wdata), .wr_ready(wr_ready),
    .cursor(b_cur), .selection(b_sel), .sel_valid(b_sv), .player_turn(b_turn),
    .state(b_state), .move_count(b_cnt), .err_timeout(b_err));

  user_move_ctrl #(.ROWS(6), .COLS(10), .WRAP(0), .REPEAT_CYC(0), .CHK_TIMEOUT(10)) u_c (
    .clk(clk), .reset(reset), .board_flat(board6),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .chk_req(c_req), .chk_ack(chk_ack), .chk_ok(chk_ok),
    .wr_en(c_wen), .wr_addr(c_waddr), .wr_data(c_wdata), .wr_ready(wr_ready),
    .cursor(c_cur), .selection(c_sel), .sel_valid(c_sv), .player_turn(c_turn),
    .state(c_state), .move_count(c_cnt), .err_timeout(c_err));

  typedef struct {
    logic [4:0] btn;
    int         cur;
    int         st;
    int         sv;
    int         sel;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add(input logic [4:0] b, input int cur, input int st, input int sv, input int sel);
    vec_t v;
    v.btn = b; v.cur = cur; v.st = st; v.sv = sv; v.sel = sel;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btn_c, btn_u, btn_d, btn_r, btn_l} = m;
  endtask

  // One-cycle press then one-cycle release: exactly one rising edge.
  task automatic press(input logic [4:0] m);
    set_btns(m);
    step();
    set_btns(5'b0);
    step();
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    chk_ack = 0; chk_ok = 0; wr_ready = 0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // u_a: select 16 (piece 2), move to empty 24, commit; ends on the edge that enters CHECK.
  task automatic go_check();
    press(B_D);
    press(B_D);
    press(B_C);
    press(B_D);
    btn_c = 1'b1;
    step();
    btn_c = 1'b0;
  endtask

  initial begin
    board8 = '0;
    board8[12*4 +: 4] = 4'h1;
    board8[16*4 +: 4] = 4'h2;
    board8[20*4 +: 4] = 4'h9;
    board6 = '0;
    board6[59*4 +: 4] = 4'h3;

    // Reset state
    step();
    step();
    check("rst state", int'(a_state), 0);
    check("rst cursor", int'(a_cur), 0);
    check("rst selection", int'(a_sel), 0);
    check("rst sel_valid", int'(a_sv), 0);
    check("rst turn", int'(a_turn), 0);
    check("rst chk_req", int'(a_req), 0);
    check("rst wr_en", int'(a_wen), 0);
    check("rst wr_addr", int'(a_waddr), 0);
    check("rst wr_data", int'(a_wdata), 0);
    check("rst move_count", int'(a_cnt), 0);
    check("rst err_timeout", int'(a_err), 0);
    reset = 1'b0;
    check("idle before edge", int'(a_state), 0);
    step();
    check("idle to select", int'(a_state), 1);

    // Navigation / select table on u_a (clamping 8x8)
    add(B_D,       8, 1, 0, 0);
    add(B_D,      16, 1, 0, 0);
    add(B_U | B_D, 8, 1, 0, 0);
    add(B_D,      16, 1, 0, 0);
    add(B_R | B_L, 17, 1, 0, 0);
    add(B_L,      16, 1, 0, 0);
    add(B_C,      16, 2, 1, 16);
    add(B_U,       8, 2, 1, 16);
    add(B_R,       9, 2, 1, 16);
    add(B_L,       8, 2, 1, 16);
    add(B_L,       8, 2, 1, 16);
    add(B_U,       0, 2, 1, 16);
    add(B_U,       0, 2, 1, 16);
    add(B_D,       8, 2, 1, 16);
    add(B_D,      16, 2, 1, 16);
    add(B_C,      16, 1, 0, 16);
    add(B_R,      17, 1, 0, 16);
    add(B_R,      18, 1, 0, 16);
    add(B_R,      19, 1, 0, 16);
    add(B_R,      20, 1, 0, 16);
    add(B_C,      20, 1, 0, 16);
    add(B_L,      19, 1, 0, 16);
    add(B_C,      19, 1, 0, 16);
    add(B_U,      11, 1, 0, 16);
    add(B_R,      12, 1, 0, 16);
    add(B_C,      12, 2, 1, 12);
    add(B_D,      20, 2, 1, 12);
    add(B_L,      19, 2, 1, 12);
    add(B_L,      18, 2, 1, 12);
    add(B_L,      17, 2, 1, 12);
    add(B_L,      16, 2, 1, 12);
    add(B_C,      16, 2, 1, 16);
    add(B_U,       8, 2, 1, 16);
    add(B_R,       9, 2, 1, 16);
    add(B_R,      10, 2, 1, 16);
    add(B_R,      11, 2, 1, 16);
    add(B_R,      12, 2, 1, 16);
    add(B_C,      12, 2, 1, 12);
    add(B_D,      20, 2, 1, 12);
    add(B_D,      28, 2, 1, 12);

    foreach (tbl[i]) begin
      press(tbl[i].btn);
      check($sformatf("vec%0d cursor", i), int'(a_cur), tbl[i].cur);
      check($sformatf("vec%0d state", i), int'(a_state), tbl[i].st);
      check($sformatf("vec%0d sel_valid", i), int'(a_sv), tbl[i].sv);
      check($sformatf("vec%0d selection", i), int'(a_sel), tbl[i].sel);
    end

    // Commit 12 -> 28 with a stalled PLACE write
    chk_ok = 1'b1;
    btn_c = 1'b1;
    step();
    btn_c = 1'b0;
    check("commit check state", int'(a_state), 3);
    check("commit chk_req", int'(a_req), 1);
    step();
    step();
    check("commit req held", int'(a_req), 1);
    chk_ack = 1'b1;
    step();
    chk_ack = 1'b0;
    check("place state", int'(a_state), 4);
    check("place req dropped", int'(a_req), 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("place stall%0d wr_en", i), int'(a_wen), 1);
      check($sformatf("place stall%0d addr", i), int'(a_waddr), 28);
      check($sformatf("place stall%0d data", i), int'(a_wdata), 1);
      step();
    end
    check("place still", int'(a_state), 4);
    wr_ready = 1'b1;
    step();
    check("clear state", int'(a_state), 5);
    check("clear wr_en", int'(a_wen), 1);
    check("clear addr", int'(a_waddr), 12);
    check("clear data", int'(a_wdata), 0);
    step();
    wr_ready = 1'b0;
    check("done state", int'(a_state), 1);
    check("done wr_en", int'(a_wen), 0);
    check("done turn", int'(a_turn), 1);
    check("done count", int'(a_cnt), 1);
    check("done sel_valid", int'(a_sv), 0);

    // Checker timeout (CHK_TIMEOUT=10)
    do_reset();
    go_check();
    check("tmo enter", int'(a_state), 3);
    for (int i = 1; i < 10; i++) begin
      step();
      check($sformatf("tmo wait%0d", i), int'(a_err), 0);
    end
    check("tmo req before", int'(a_req), 1);
    step();
    check("tmo pulse", int'(a_err), 1);
    check("tmo state", int'(a_state), 1);
    check("tmo req", int'(a_req), 0);
    check("tmo sel_valid", int'(a_sv), 0);
    check("tmo turn", int'(a_turn), 0);
    step();
    check("tmo pulse one cycle", int'(a_err), 0);

    // Checker reject
    do_reset();
    go_check();
    step();
    chk_ack = 1'b1; chk_ok = 1'b0;
    step();
    chk_ack = 1'b0;
    check("rej state", int'(a_state), 1);
    check("rej sel_valid", int'(a_sv), 0);
    check("rej err", int'(a_err), 0);
    check("rej count", int'(a_cnt), 0);
    check("rej wr_en", int'(a_wen), 0);

    // Reset asserted mid-CLEAR
    do_reset();
    go_check();
    chk_ack = 1'b1; chk_ok = 1'b1;
    step();
    chk_ack = 1'b0;
    check("mc place addr", int'(a_waddr), 24);
    check("mc place data", int'(a_wdata), 2);
    wr_ready = 1'b1;
    step();
    wr_ready = 1'b0;
    check("mc clear addr", int'(a_waddr), 16);
    step();
    check("mc clear held", int'(a_state), 5);
    #3 reset = 1'b1;
    #1;
    check("mc async wr_en", int'(a_wen), 0);
    check("mc state", int'(a_state), 0);
    check("mc wr_addr", int'(a_waddr), 0);
    check("mc cursor", int'(a_cur), 0);
    check("mc sel_valid", int'(a_sv), 0);
    check("mc selection", int'(a_sel), 0);
    check("mc count", int'(a_cnt), 0);

    // Wrap and auto-repeat on u_b
    do_reset();
    press(B_U);
    check("wrap up", int'(b_cur), 56);
    press(B_L);
    check("wrap left", int'(b_cur), 63);
    press(B_D);
    check("wrap down", int'(b_cur), 7);
    press(B_R);
    check("wrap right", int'(b_cur), 0);
    btn_r = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 4) check("rep before first", int'(b_cur), 1);
      if (i == 5) check("rep first", int'(b_cur), 2);
    end
    btn_r = 1'b0;
    step();
    check("rep total", int'(b_cur), 5);

    // 6x10 board on u_c
    do_reset();
    press(B_U);
    press(B_L);
    check("c6 clamp origin", int'(c_cur), 0);
    for (int i = 0; i < 6; i++) press(B_D);
    check("c6 clamp bottom", int'(c_cur), 50);
    for (int i = 0; i < 10; i++) press(B_R);
    check("c6 clamp right", int'(c_cur), 59);
    press(B_C);
    check("c6 armed", int'(c_state), 2);
    check("c6 selection", int'(c_sel), 59);
    press(B_L);
    btn_c = 1'b1;
    step();
    btn_c = 1'b0;
    check("c6 check", int'(c_state), 3);
    chk_ack = 1'b1; chk_ok = 1'b1; wr_ready = 1'b1;
    step();
    chk_ack = 1'b0;
    check("c6 place addr", int'(c_waddr), 58);
    check("c6 place data", int'(c_wdata), 3);
    step();
    check("c6 clear addr", int'(c_waddr), 59);
    check("c6 clear data", int'(c_wdata), 0);
    step();
    wr_ready = 1'b0;
    check("c6 done state", int'(c_state), 1);
    check("c6 done turn", int'(c_turn), 1);
    check("c6 done count", int'(c_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
